// File: rtl/rom_load_sequencer_if.sv
// rom_load_sequencer_if: ioctl download stream in, ROM write strobes and core reset control out
//   master: drives user_reset and ioctl_*, observes the ROM write and status signals
//   slave : the sequencer side (consumes ioctl_*, drives rom_*, core_reset and status)
//   rom_sum exists only when ROM_LOAD_CHECKSUM_EN is defined
interface rom_load_if;
    logic        user_reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [2:0]  rom_we;
    logic        core_reset;
    logic        rom_ready;
    logic        load_err;
    logic [15:0] byte_count;
`ifdef ROM_LOAD_CHECKSUM_EN
    logic [7:0]  rom_sum;
`endif
    modport master (
        output user_reset, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  rom_addr, rom_data, rom_we, core_reset, rom_ready, load_err, byte_count
`ifdef ROM_LOAD_CHECKSUM_EN
        , rom_sum
`endif
    );
    modport slave (
        input  user_reset, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output rom_addr, rom_data, rom_we, core_reset, rom_ready, load_err, byte_count
`ifdef ROM_LOAD_CHECKSUM_EN
        , rom_sum
`endif
    );
endinterface

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: decodes ioctl download bytes into ROM region writes and sequences the core reset
//   CLK   : system clock
//   RESET : asynchronous active-high reset
//   bus   : rom_load_if.slave (ioctl stream in; rom_addr/rom_data/rom_we, core_reset, rom_ready,
//           load_err, byte_count out)
//   Optional: ROM_LOAD_CHECKSUM_EN adds rom_sum and the EXPECT_SUM check at download end.
module rom_load_sequencer #(
    parameter logic [15:0] REG0_END    = 16'h4000,
    parameter logic [15:0] REG1_END    = 16'h6000,
    parameter logic [15:0] REG2_END    = 16'h6120,
`ifdef ROM_LOAD_CHECKSUM_EN
    parameter logic [7:0]  EXPECT_SUM  = 8'h00,
`endif
    parameter int          HOLD_CYCLES = 64
) (
    input logic         CLK,
    input logic         RESET,
    rom_load_if.slave   bus
);
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
    state_t        state_q, state_d;
    logic          dl_q;
    logic [HW-1:0] hc_q, hc_d;
    logic [15:0]   addr_q, addr_d, bc_q, bc_d;
    logic [7:0]    data_q, data_d, sum_q, sum_d;
    logic [2:0]    we_q, we_d;
    logic          crst_q, crst_d, rdy_q, rdy_d, err_q, err_d;
    logic          rise, fall, in_range, sum_ok;
    assign rise     = bus.ioctl_download & ~dl_q;
    assign fall     = ~bus.ioctl_download & dl_q;
    assign in_range = bus.ioctl_addr < REG2_END;
`ifdef ROM_LOAD_CHECKSUM_EN
    assign sum_ok      = sum_q == EXPECT_SUM;
    assign bus.rom_sum = sum_q;
`else
    assign sum_ok = 1'b1;
`endif
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = '0;
        bc_d    = bc_q;
        sum_d   = sum_q;
        err_d   = err_q;
        if (rise) begin
            // A new download overrides everything, including a pending user_reset or hold.
            state_d = LOAD;
            bc_d    = '0;
            sum_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (fall) begin
                        state_d = (bc_q >= REG2_END && sum_ok) ? HOLD : IDLE;
                        hc_d    = HW'(HOLD_CYCLES - 1);
                        err_d   = !(bc_q >= REG2_END && sum_ok);
                    end else if (bus.ioctl_wr && in_range) begin
                        we_d   = bus.ioctl_addr < REG0_END ? 3'b001 :
                                 bus.ioctl_addr < REG1_END ? 3'b010 : 3'b100;
                        addr_d = bus.ioctl_addr < REG0_END ? bus.ioctl_addr :
                                 bus.ioctl_addr < REG1_END ? bus.ioctl_addr - REG0_END :
                                                             bus.ioctl_addr - REG1_END;
                        data_d = bus.ioctl_dout;
                        bc_d   = &bc_q ? bc_q : bc_q + 16'd1;
                        sum_d  = sum_q + bus.ioctl_dout;
                    end
                end
                HOLD: begin
                    state_d = (!bus.user_reset && hc_q == '0) ? RUN : HOLD;
                    hc_d    = bus.user_reset ? HW'(HOLD_CYCLES - 1) : (hc_q == '0 ? hc_q : hc_q - 1'b1);
                end
                RUN: begin
                    state_d = bus.user_reset ? HOLD : RUN;
                    hc_d    = HW'(HOLD_CYCLES - 1);
                end
                default: ;
            endcase
        end
        // Registering core_reset from the next state makes it fall in the same cycle RUN is entered.
        crst_d = state_d != RUN;
        rdy_d  = rise ? 1'b0 : (state_d == RUN ? 1'b1 : rdy_q);
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            dl_q    <= 1'b0;
            hc_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= '0;
            bc_q    <= '0;
            sum_q   <= '0;
            crst_q  <= 1'b1;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q    <= bus.ioctl_download;
            hc_q    <= hc_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            bc_q    <= bc_d;
            sum_q   <= sum_d;
            crst_q  <= crst_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end
    assign bus.rom_addr   = addr_q;
    assign bus.rom_data   = data_q;
    assign bus.rom_we     = we_q;
    assign bus.core_reset = crst_q;
    assign bus.rom_ready  = rdy_q;
    assign bus.load_err   = err_q;
    assign bus.byte_count = bc_q;
endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer: directed self-checking bench for rom_load_sequencer
module tb_rom_load_sequencer;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    rom_load_if bus();
    rom_load_sequencer dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic wr_byte(input logic [15:0] a, input logic [7:0] d);
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask
    task automatic start_dl();
        bus.ioctl_download = 1'b1;
        tick();
    endtask
    task automatic end_dl();
        bus.ioctl_download = 1'b0;
        tick();
    endtask
    task automatic pulse_user_reset();
        bus.user_reset = 1'b1;
        tick();
        bus.user_reset = 1'b0;
    endtask
    // Even/odd data pair sums to 0x100 so an even-length image has a zero checksum.
    task automatic load_bytes(input int n, input logic probe);
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            a = 16'(i);
            if (probe && a == 16'h1000) begin
                wr_byte(16'h7000, 8'h33);
                check("oor_we", 32'(bus.rom_we), 32'h0);
                check("oor_count", 32'(bus.byte_count), 32'h1000);
            end
            wr_byte(a, a[0] ? 8'hA5 : 8'h5B);
            if (probe && a == 16'h3FFF) begin
                check("cpu_we", 32'(bus.rom_we), 32'h1);
                check("cpu_addr", 32'(bus.rom_addr), 32'h3FFF);
                check("cpu_data", 32'(bus.rom_data), 32'hA5);
            end
            if (probe && a == 16'h4000) begin
                check("gfx_we", 32'(bus.rom_we), 32'h2);
                check("gfx_addr", 32'(bus.rom_addr), 32'h0);
                check("gfx_data", 32'(bus.rom_data), 32'h5B);
            end
            if (probe && a == 16'h6000) begin
                check("prom_we", 32'(bus.rom_we), 32'h4);
                check("prom_addr", 32'(bus.rom_addr), 32'h0);
            end
        end
    endtask
    // Counts cycles until core_reset falls (bounded) and whether rom_ready held high throughout.
    task automatic wait_release(output int n, output logic rdy_all);
        n = 0;
        rdy_all = 1'b1;
        while (bus.core_reset && n < 200) begin
            rdy_all &= bus.rom_ready;
            tick();
            n++;
        end
    endtask
    initial begin
        int   n;
        logic r, any_we, any_rel;
        bus.user_reset = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = '0;
        bus.ioctl_dout = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_core_reset", 32'(bus.core_reset), 32'h1);
        check("rst_rom_ready", 32'(bus.rom_ready), 32'h0);
        check("rst_load_err", 32'(bus.load_err), 32'h0);
        check("rst_rom_we", 32'(bus.rom_we), 32'h0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        check("rst_rom_data", 32'(bus.rom_data), 32'h0);
        check("rst_byte_count", 32'(bus.byte_count), 32'h0);
        RESET = 1'b0;
        any_we = 1'b0;
        any_rel = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_we |= |bus.rom_we;
            any_rel |= ~bus.core_reset | bus.rom_ready;
        end
        check("idle_no_we", 32'(any_we), 32'h0);
        check("idle_held", 32'(any_rel), 32'h0);
        start_dl();
        load_bytes(32'h6120, 1'b1);
        end_dl();
        check("full_we_pulse_end", 32'(bus.rom_we), 32'h0);
        check("full_count", 32'(bus.byte_count), 32'h6120);
        check("full_err", 32'(bus.load_err), 32'h0);
        check("full_hold_reset", 32'(bus.core_reset), 32'h1);
        wait_release(n, r);
        check("full_hold_len", 32'(n), 32'd64);
        check("full_ready", 32'(bus.rom_ready), 32'h1);
        pulse_user_reset();
        check("ur_core_reset", 32'(bus.core_reset), 32'h1);
        wait_release(n, r);
        check("ur_hold_len", 32'(n), 32'd64);
        check("ur_ready_kept", 32'(r & bus.rom_ready), 32'h1);
        pulse_user_reset();
        repeat (10) tick();
        start_dl();
        check("midhold_core_reset", 32'(bus.core_reset), 32'h1);
        check("midhold_ready", 32'(bus.rom_ready), 32'h0);
        check("midhold_count", 32'(bus.byte_count), 32'h0);
        load_bytes(32'h5000, 1'b0);
        end_dl();
        check("short_err", 32'(bus.load_err), 32'h1);
        check("short_count", 32'(bus.byte_count), 32'h5000);
        pulse_user_reset();
        repeat (80) tick();
        check("short_core_reset", 32'(bus.core_reset), 32'h1);
        check("short_ready", 32'(bus.rom_ready), 32'h0);
        check("short_err_kept", 32'(bus.load_err), 32'h1);
        start_dl();
        check("reload_err_clr", 32'(bus.load_err), 32'h0);
        load_bytes(32'h6120, 1'b0);
        end_dl();
        wait_release(n, r);
        check("run2_hold_len", 32'(n), 32'd64);
        start_dl();
        check("run_dl_core_reset", 32'(bus.core_reset), 32'h1);
        check("run_dl_ready", 32'(bus.rom_ready), 32'h0);
        check("run_dl_count", 32'(bus.byte_count), 32'h0);
        wr_byte(16'h0000, 8'h01);
        wr_byte(16'h0001, 8'h02);
        wr_byte(16'h0002, 8'h03);
`ifdef ROM_LOAD_CHECKSUM_EN
        check("sum_123", 32'(bus.rom_sum), 32'h06);
`endif
        check("three_count", 32'(bus.byte_count), 32'h3);
        end_dl();
        check("three_err", 32'(bus.load_err), 32'h1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
